// File: rtl/hazard_unit_sb_pkg.sv
// Shared constants and helpers for the ID/EX hazard unit and its scoreboard.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int DEF_REG_AW   = 5;
  localparam int DEF_NUM_REGS = 32;

  // Widest register index the match helper handles; callers zero-extend into it.
  localparam int MAX_AW = 8;

  // True when a producer writes a real register (not x0) that the consumer reads.
  function automatic logic rd_match(input logic [MAX_AW-1:0] rd,
                                    input logic [MAX_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_unit_sb_if import hazard_pkg::*; #(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int CNT_W    = 16
) ();

  logic [REG_AW-1:0]   id_rs1;
  logic [REG_AW-1:0]   id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [REG_AW-1:0]   id_rd;
  logic                id_reg_write;
  logic                id_is_mdu;
  logic                id_valid;
  logic                ex_mem_read;
  logic [REG_AW-1:0]   ex_rd;
  logic [REG_AW-1:0]   mem_rd;
  logic [REG_AW-1:0]   wb_rd;
  logic                mem_reg_write;
  logic                wb_reg_write;
  logic                mdu_issue;
  logic [REG_AW-1:0]   mdu_issue_rd;
  logic                mdu_done;
  logic [REG_AW-1:0]   mdu_done_rd;
  logic                mdu_busy;
  logic                branch_taken;

  logic                stall;
  logic                flush_if_id;
  logic                flush_id_ex;
  logic [1:0]          forward_a;
  logic [1:0]          forward_b;
  logic [NUM_REGS-1:0] sb_busy;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
           id_is_mdu, id_valid, ex_mem_read, ex_rd, mem_rd, wb_rd,
           mem_reg_write, wb_reg_write, mdu_issue, mdu_issue_rd, mdu_done,
           mdu_done_rd, mdu_busy, branch_taken,
    input  stall, flush_if_id, flush_id_ex, forward_a, forward_b, sb_busy,
           stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write,
           id_is_mdu, id_valid, ex_mem_read, ex_rd, mem_rd, wb_rd,
           mem_reg_write, wb_reg_write, mdu_issue, mdu_issue_rd, mdu_done,
           mdu_done_rd, mdu_busy, branch_taken,
    output stall, flush_if_id, flush_id_ex, forward_a, forward_b, sb_busy,
           stall_cycles
  );

endinterface

// File: rtl/hazard_unit_sb_scoreboard.sv
// Per-register busy bits for in-flight MDU results, with RAW/WAW lookups for ID.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic                done,
  input  logic [REG_AW-1:0]   done_rd,
  input  logic [REG_AW-1:0]   rs1,
  input  logic [REG_AW-1:0]   rs2,
  input  logic [REG_AW-1:0]   rd,
  output logic [NUM_REGS-1:0] busy,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy
);

  logic [NUM_REGS-1:0] busy_nxt;

  // Clear on completion first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (done) busy_nxt[done_rd] = 1'b0;
    if (issue && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign rd_busy  = busy[rd];

endmodule

// File: rtl/hazard_unit_sb.sv
// ID/EX hazard unit: forwarding, load-use bubbles, MDU scoreboard stalls,
// branch flush (overrides stall) and a saturating stall-cycle counter.
module hazard_unit_sb import hazard_pkg::*; #(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int REG_AW       = DEF_REG_AW,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst_n,
  hazard_unit_sb_if.slave hif
);

  // Extra bubbles beyond the detection cycle; 0 when a single bubble suffices.
  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

  logic [1:0]       bub_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rd_busy;
  logic             load_use;
  logic             sb_stall;
  logic             flush;
  logic             stall_int;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (hif.mdu_issue),
    .issue_rd (hif.mdu_issue_rd),
    .done     (hif.mdu_done),
    .done_rd  (hif.mdu_done_rd),
    .rs1      (hif.id_rs1),
    .rs2      (hif.id_rs2),
    .rd       (hif.id_rd),
    .busy     (hif.sb_busy),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Operand forwarding; the younger MEM result shadows WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (hif.mem_reg_write && rd_match(MAX_AW'(hif.mem_rd), MAX_AW'(hif.id_rs1)))
      fwd_a = FWD_MEM;
    else if (hif.wb_reg_write && rd_match(MAX_AW'(hif.wb_rd), MAX_AW'(hif.id_rs1)))
      fwd_a = FWD_WB;
    if (hif.mem_reg_write && rd_match(MAX_AW'(hif.mem_rd), MAX_AW'(hif.id_rs2)))
      fwd_b = FWD_MEM;
    else if (hif.wb_reg_write && rd_match(MAX_AW'(hif.wb_rd), MAX_AW'(hif.id_rs2)))
      fwd_b = FWD_WB;
  end

  // Stall sources; MDU results are not forwarded, so busy registers must wait for writeback.
  always_comb begin
    load_use = hif.id_valid && hif.ex_mem_read &&
               ((hif.id_rs1_used && rd_match(MAX_AW'(hif.ex_rd), MAX_AW'(hif.id_rs1))) ||
                (hif.id_rs2_used && rd_match(MAX_AW'(hif.ex_rd), MAX_AW'(hif.id_rs2))));
    sb_stall = hif.id_valid &&
               ((hif.id_rs1_used && rs1_busy) ||
                (hif.id_rs2_used && rs2_busy) ||
                (hif.id_reg_write && rd_busy) ||
                (hif.id_is_mdu && hif.mdu_busy));
    flush     = hif.branch_taken;
    stall_int = !flush && (load_use || (bub_cnt != 2'd0) || sb_stall);
  end

  // Bubble counter: extends a load-use stall; a redirect abandons the remaining bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         bub_cnt <= 2'd0;
    else if (flush)                     bub_cnt <= 2'd0;
    else if (bub_cnt != 2'd0)           bub_cnt <= bub_cnt - 2'd1;
    else if (load_use)                  bub_cnt <= BUB_INIT;
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cnt <= '0;
    else if (stall_int && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign hif.stall        = stall_int;
  assign hif.flush_if_id  = flush;
  assign hif.flush_id_ex  = flush;
  assign hif.forward_a    = fwd_a;
  assign hif.forward_b    = fwd_b;
  assign hif.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench: four hazard units share one stimulus; instances 0..2 use
// LOAD_BUBBLES 1..3, instance 3 has a 3-bit counter to exercise saturation.
module tb_hazard_unit_sb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd, mdu_issue_rd, mdu_done_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_write, id_is_mdu, id_valid, ex_mem_read;
  logic       mem_reg_write, wb_reg_write, mdu_issue, mdu_done, mdu_busy, branch_taken;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int LB = (g == 3) ? 1 : g + 1;
    localparam int CW = (g == 3) ? 3 : 16;
    hazard_unit_sb_if #(.REG_AW(5), .NUM_REGS(32), .CNT_W(CW)) hif ();
    assign hif.id_rs1        = id_rs1;
    assign hif.id_rs2        = id_rs2;
    assign hif.id_rs1_used   = id_rs1_used;
    assign hif.id_rs2_used   = id_rs2_used;
    assign hif.id_rd         = id_rd;
    assign hif.id_reg_write  = id_reg_write;
    assign hif.id_is_mdu     = id_is_mdu;
    assign hif.id_valid      = id_valid;
    assign hif.ex_mem_read   = ex_mem_read;
    assign hif.ex_rd         = ex_rd;
    assign hif.mem_rd        = mem_rd;
    assign hif.wb_rd         = wb_rd;
    assign hif.mem_reg_write = mem_reg_write;
    assign hif.wb_reg_write  = wb_reg_write;
    assign hif.mdu_issue     = mdu_issue;
    assign hif.mdu_issue_rd  = mdu_issue_rd;
    assign hif.mdu_done      = mdu_done;
    assign hif.mdu_done_rd   = mdu_done_rd;
    assign hif.mdu_busy      = mdu_busy;
    assign hif.branch_taken  = branch_taken;
    hazard_unit_sb #(.NUM_REGS(32), .REG_AW(5), .LOAD_BUBBLES(LB), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hif   (hif)
    );
  end

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    mdu_issue_rd = '0; mdu_done_rd = '0;
    id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0; id_is_mdu = 0; id_valid = 0;
    ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0; mdu_issue = 0; mdu_done = 0;
    mdu_busy = 0; branch_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_use_stim();
    id_valid = 1; ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #3;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL rst_stall: got %b want 0", gen_dut[0].hif.stall); end
    compared++; if (gen_dut[0].hif.forward_a !== 2'b00) begin mismatched++; $display("FAIL rst_fwd_a: got %b want 00", gen_dut[0].hif.forward_a); end
    compared++; if (gen_dut[0].hif.forward_b !== 2'b00) begin mismatched++; $display("FAIL rst_fwd_b: got %b want 00", gen_dut[0].hif.forward_b); end
    compared++; if (gen_dut[2].hif.sb_busy !== 32'h0) begin mismatched++; $display("FAIL rst_sb_busy: got %h want 0", gen_dut[2].hif.sb_busy); end
    compared++; if (gen_dut[2].hif.stall_cycles !== 16'd0) begin mismatched++; $display("FAIL rst_cnt: got %0d want 0", gen_dut[2].hif.stall_cycles); end
    compared++; if (gen_dut[0].hif.flush_if_id !== 1'b0) begin mismatched++; $display("FAIL rst_flush: got %b want 0", gen_dut[0].hif.flush_if_id); end
    #7 rst_n = 1;
    tick();
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL rst_rel_stall: got %b want 0", gen_dut[0].hif.stall); end
  endtask

  task automatic test_forward();
    tick();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1; wb_reg_write = 1; id_rs2 = 5'd7;
    #1;
    compared++; if (gen_dut[0].hif.forward_b !== 2'b10) begin mismatched++; $display("FAIL fwd_mem_prio: got %b want 10", gen_dut[0].hif.forward_b); end
    compared++; if (gen_dut[0].hif.forward_a !== 2'b00) begin mismatched++; $display("FAIL fwd_a_none: got %b want 00", gen_dut[0].hif.forward_a); end
    mem_reg_write = 0; id_rs1 = 5'd7;
    #1;
    compared++; if (gen_dut[0].hif.forward_b !== 2'b01) begin mismatched++; $display("FAIL fwd_wb: got %b want 01", gen_dut[0].hif.forward_b); end
    compared++; if (gen_dut[0].hif.forward_a !== 2'b01) begin mismatched++; $display("FAIL fwd_a_wb: got %b want 01", gen_dut[0].hif.forward_a); end
    mem_rd = 5'd3; mem_reg_write = 1; id_rs1 = 5'd3;
    #1;
    compared++; if (gen_dut[0].hif.forward_a !== 2'b10) begin mismatched++; $display("FAIL fwd_a_mem: got %b want 10", gen_dut[0].hif.forward_a); end
    compared++; if (gen_dut[0].hif.forward_b !== 2'b01) begin mismatched++; $display("FAIL fwd_b_wb2: got %b want 01", gen_dut[0].hif.forward_b); end
    mem_rd = 5'd0; wb_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    compared++; if (gen_dut[0].hif.forward_a !== 2'b00) begin mismatched++; $display("FAIL fwd_a_x0: got %b want 00", gen_dut[0].hif.forward_a); end
    compared++; if (gen_dut[0].hif.forward_b !== 2'b00) begin mismatched++; $display("FAIL fwd_b_x0: got %b want 00", gen_dut[0].hif.forward_b); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    tick();
    load_use_stim();
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b1) begin mismatched++; $display("FAIL lu_detect_lb1: got %b want 1", gen_dut[0].hif.stall); end
    compared++; if (gen_dut[2].hif.stall !== 1'b1) begin mismatched++; $display("FAIL lu_detect_lb3: got %b want 1", gen_dut[2].hif.stall); end
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL lu_lb1_release: got %b want 0", gen_dut[0].hif.stall); end
    compared++; if (gen_dut[0].hif.stall_cycles !== 16'd1) begin mismatched++; $display("FAIL lu_lb1_cnt: got %0d want 1", gen_dut[0].hif.stall_cycles); end
    compared++; if (gen_dut[1].hif.stall !== 1'b1) begin mismatched++; $display("FAIL lu_lb2_hold: got %b want 1", gen_dut[1].hif.stall); end
    tick();
    compared++; if (gen_dut[1].hif.stall !== 1'b0) begin mismatched++; $display("FAIL lu_lb2_release: got %b want 0", gen_dut[1].hif.stall); end
    compared++; if (gen_dut[1].hif.stall_cycles !== 16'd2) begin mismatched++; $display("FAIL lu_lb2_cnt: got %0d want 2", gen_dut[1].hif.stall_cycles); end
    compared++; if (gen_dut[2].hif.stall !== 1'b1) begin mismatched++; $display("FAIL lu_lb3_hold: got %b want 1", gen_dut[2].hif.stall); end
    tick();
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL lu_lb3_release: got %b want 0", gen_dut[2].hif.stall); end
    compared++; if (gen_dut[2].hif.stall_cycles !== 16'd3) begin mismatched++; $display("FAIL lu_lb3_cnt: got %0d want 3", gen_dut[2].hif.stall_cycles); end
    id_valid = 1; ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 0;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL lu_unused_rs: got %b want 0", gen_dut[0].hif.stall); end
    id_rs2_used = 1;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b1) begin mismatched++; $display("FAIL lu_rs2: got %b want 1", gen_dut[0].hif.stall); end
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL lu_x0: got %b want 0", gen_dut[0].hif.stall); end
    ex_rd = 5'd5; id_rs2 = 5'd5; id_valid = 0;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL lu_invalid: got %b want 0", gen_dut[0].hif.stall); end
    clear_inputs();
  endtask

  task automatic test_scoreboard();
    tick();
    mdu_issue = 1; mdu_issue_rd = 5'd9;
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[0].hif.sb_busy !== 32'h0000_0200) begin mismatched++; $display("FAIL sb_set: got %h want 00000200", gen_dut[0].hif.sb_busy); end
    id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b1) begin mismatched++; $display("FAIL sb_raw: got %b want 1", gen_dut[0].hif.stall); end
    tick();
    compared++; if (gen_dut[0].hif.stall !== 1'b1) begin mismatched++; $display("FAIL sb_raw_hold: got %b want 1", gen_dut[0].hif.stall); end
    tick();
    mdu_done = 1; mdu_done_rd = 5'd9;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b1) begin mismatched++; $display("FAIL sb_done_cycle: got %b want 1", gen_dut[0].hif.stall); end
    tick();
    mdu_done = 0;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL sb_release: got %b want 0", gen_dut[0].hif.stall); end
    compared++; if (gen_dut[0].hif.sb_busy !== 32'h0) begin mismatched++; $display("FAIL sb_clear: got %h want 0", gen_dut[0].hif.sb_busy); end
    compared++; if (gen_dut[0].hif.stall_cycles !== 16'd4) begin mismatched++; $display("FAIL sb_cnt: got %0d want 4", gen_dut[0].hif.stall_cycles); end
    clear_inputs();
    mdu_issue = 1; mdu_issue_rd = 5'd9; mdu_done = 1; mdu_done_rd = 5'd9;
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[0].hif.sb_busy !== 32'h0000_0200) begin mismatched++; $display("FAIL sb_set_wins: got %h want 00000200", gen_dut[0].hif.sb_busy); end
    id_valid = 1; id_reg_write = 1; id_rd = 5'd9;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b1) begin mismatched++; $display("FAIL sb_waw: got %b want 1", gen_dut[0].hif.stall); end
    id_reg_write = 0; id_is_mdu = 1; mdu_busy = 1;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b1) begin mismatched++; $display("FAIL sb_struct: got %b want 1", gen_dut[0].hif.stall); end
    id_valid = 0;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL sb_struct_invalid: got %b want 0", gen_dut[0].hif.stall); end
    clear_inputs();
    mdu_done = 1; mdu_done_rd = 5'd4; mdu_issue = 1; mdu_issue_rd = 5'd0;
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[0].hif.sb_busy !== 32'h0000_0200) begin mismatched++; $display("FAIL sb_noop: got %h want 00000200", gen_dut[0].hif.sb_busy); end
    mdu_done = 1; mdu_done_rd = 5'd9;
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[0].hif.sb_busy !== 32'h0) begin mismatched++; $display("FAIL sb_clear2: got %h want 0", gen_dut[0].hif.sb_busy); end
    compared++; if (gen_dut[0].hif.stall_cycles !== 16'd4) begin mismatched++; $display("FAIL sb_cnt2: got %0d want 4", gen_dut[0].hif.stall_cycles); end
  endtask

  task automatic test_flush();
    tick();
    load_use_stim();
    branch_taken = 1;
    #1;
    compared++; if (gen_dut[0].hif.stall !== 1'b0) begin mismatched++; $display("FAIL fl_stall_lb1: got %b want 0", gen_dut[0].hif.stall); end
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL fl_stall_lb3: got %b want 0", gen_dut[2].hif.stall); end
    compared++; if (gen_dut[0].hif.flush_if_id !== 1'b1) begin mismatched++; $display("FAIL fl_if_id: got %b want 1", gen_dut[0].hif.flush_if_id); end
    compared++; if (gen_dut[0].hif.flush_id_ex !== 1'b1) begin mismatched++; $display("FAIL fl_id_ex: got %b want 1", gen_dut[0].hif.flush_id_ex); end
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL fl_no_bubble: got %b want 0", gen_dut[2].hif.stall); end
    compared++; if (gen_dut[0].hif.stall_cycles !== 16'd4) begin mismatched++; $display("FAIL fl_cnt_lb1: got %0d want 4", gen_dut[0].hif.stall_cycles); end
    compared++; if (gen_dut[2].hif.stall_cycles !== 16'd6) begin mismatched++; $display("FAIL fl_cnt_lb3: got %0d want 6", gen_dut[2].hif.stall_cycles); end
    compared++; if (gen_dut[0].hif.flush_id_ex !== 1'b0) begin mismatched++; $display("FAIL fl_deassert: got %b want 0", gen_dut[0].hif.flush_id_ex); end
    load_use_stim();
    tick();
    clear_inputs();
    branch_taken = 1;
    #1;
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL fl_mid_bubble: got %b want 0", gen_dut[2].hif.stall); end
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL fl_bubble_killed: got %b want 0", gen_dut[2].hif.stall); end
    compared++; if (gen_dut[2].hif.stall_cycles !== 16'd7) begin mismatched++; $display("FAIL fl_cnt_mid: got %0d want 7", gen_dut[2].hif.stall_cycles); end
  endtask

  task automatic test_reset_mid_bubble();
    tick();
    load_use_stim();
    mdu_issue = 1; mdu_issue_rd = 5'd12;
    tick();
    clear_inputs();
    #1;
    compared++; if (gen_dut[2].hif.stall !== 1'b1) begin mismatched++; $display("FAIL rb_pre_stall: got %b want 1", gen_dut[2].hif.stall); end
    compared++; if (gen_dut[2].hif.sb_busy !== 32'h0000_1000) begin mismatched++; $display("FAIL rb_pre_busy: got %h want 00001000", gen_dut[2].hif.sb_busy); end
    rst_n = 0;
    #1;
    compared++; if (gen_dut[2].hif.sb_busy !== 32'h0) begin mismatched++; $display("FAIL rb_busy: got %h want 0", gen_dut[2].hif.sb_busy); end
    compared++; if (gen_dut[2].hif.stall_cycles !== 16'd0) begin mismatched++; $display("FAIL rb_cnt: got %0d want 0", gen_dut[2].hif.stall_cycles); end
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL rb_stall: got %b want 0", gen_dut[2].hif.stall); end
    #2 rst_n = 1;
    tick();
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL rb_post1: got %b want 0", gen_dut[2].hif.stall); end
    tick();
    compared++; if (gen_dut[2].hif.stall !== 1'b0) begin mismatched++; $display("FAIL rb_post2: got %b want 0", gen_dut[2].hif.stall); end
    compared++; if (gen_dut[2].hif.stall_cycles !== 16'd0) begin mismatched++; $display("FAIL rb_post_cnt: got %0d want 0", gen_dut[2].hif.stall_cycles); end
  endtask

  task automatic test_saturation();
    tick();
    id_valid = 1; id_is_mdu = 1; mdu_busy = 1;
    repeat (6) tick();
    compared++; if (gen_dut[3].hif.stall_cycles !== 3'd6) begin mismatched++; $display("FAIL sat_cnt6: got %0d want 6", gen_dut[3].hif.stall_cycles); end
    compared++; if (gen_dut[0].hif.stall_cycles !== 16'd6) begin mismatched++; $display("FAIL sat_wide6: got %0d want 6", gen_dut[0].hif.stall_cycles); end
    repeat (3) tick();
    compared++; if (gen_dut[3].hif.stall_cycles !== 3'd7) begin mismatched++; $display("FAIL sat_hold: got %0d want 7", gen_dut[3].hif.stall_cycles); end
    compared++; if (gen_dut[0].hif.stall_cycles !== 16'd9) begin mismatched++; $display("FAIL sat_wide9: got %0d want 9", gen_dut[0].hif.stall_cycles); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_flush();
    test_reset_mid_bubble();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
